// File: rtl/axistream_pkg.sv
// Shared types and helpers for the AXI-Stream building blocks.
// Holds the arbiter state encoding and the index-width helper.
package axistream_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    // Width of an index into n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axistream_reg_slice.sv
// Two-entry skid buffer for a generic valid/ready payload.
// Both in_ready and the output side are driven straight from registers.
module axistream_reg_slice #(
    parameter int WIDTH = 8
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid_reg, main_valid_next;
    logic [WIDTH-1:0] main_data_reg,  main_data_next;
    logic             skid_valid_reg, skid_valid_next;
    logic [WIDTH-1:0] skid_data_reg,  skid_data_next;
    logic             ready_reg,      ready_next;
    logic             in_fire;

    assign in_fire = in_valid && ready_reg;

    always_comb begin
        main_valid_next = main_valid_reg;
        main_data_next  = main_data_reg;
        skid_valid_next = skid_valid_reg;
        skid_data_next  = skid_data_reg;
        if (!main_valid_reg || out_ready) begin
            // Output entry frees up: refill from the skid entry first to keep order.
            if (skid_valid_reg) begin
                main_valid_next = 1'b1;
                main_data_next  = skid_data_reg;
                skid_valid_next = in_fire;
                if (in_fire) begin
                    skid_data_next = in_data;
                end
            end else begin
                main_valid_next = in_fire;
                if (in_fire) begin
                    main_data_next = in_data;
                end
            end
        end else if (in_fire) begin
            skid_valid_next = 1'b1;
            skid_data_next  = in_data;
        end
        ready_next = !(main_valid_next && skid_valid_next);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
            skid_data_reg  <= '0;
            ready_reg      <= 1'b1;
        end else begin
            main_valid_reg <= main_valid_next;
            main_data_reg  <= main_data_next;
            skid_valid_reg <= skid_valid_next;
            skid_data_reg  <= skid_data_next;
            ready_reg      <= ready_next;
        end
    end

    assign in_ready  = ready_reg;
    assign out_valid = main_valid_reg;
    assign out_data  = main_data_reg;

endmodule

// File: rtl/axistream_rr_arbiter.sv
// Packet-level round-robin merge of NUM_INPUTS AXI-Stream sources onto one output.
// A grant is held until the tlast beat is accepted; output goes through a skid slice.
module axistream_rr_arbiter
    import axistream_pkg::*;
#(
    parameter int NUM_INPUTS  = 4,
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 4,
    parameter int TDEST_WIDTH = 4
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_INPUTS-1:0]               s_tvalid,
    output logic [NUM_INPUTS-1:0]               s_tready,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0] s_tstrb,
    input  logic [NUM_INPUTS*TDATA_WIDTH/8-1:0] s_tkeep,
    input  logic [NUM_INPUTS-1:0]               s_tlast,
    input  logic [NUM_INPUTS*TID_WIDTH-1:0]     s_tid,
    input  logic [NUM_INPUTS*TDEST_WIDTH-1:0]   s_tdest,
    output logic                                m_tvalid,
    input  logic                                m_tready,
    output logic [TDATA_WIDTH-1:0]              m_tdata,
    output logic [TDATA_WIDTH/8-1:0]            m_tstrb,
    output logic [TDATA_WIDTH/8-1:0]            m_tkeep,
    output logic                                m_tlast,
    output logic [TID_WIDTH-1:0]                m_tid,
    output logic [TDEST_WIDTH-1:0]              m_tdest,
    output logic [idx_width(NUM_INPUTS)-1:0]    grant_idx,
    output logic                                busy
);

    localparam int IDXW = idx_width(NUM_INPUTS);
    localparam int KW   = TDATA_WIDTH / 8;
    localparam int PW   = TDATA_WIDTH + 2 * KW + 1 + TID_WIDTH + TDEST_WIDTH;
    localparam logic [IDXW:0]   NUM_EXT  = (IDXW + 1)'(NUM_INPUTS);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_INPUTS - 1);

    if (TDATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("axistream_rr_arbiter: TDATA_WIDTH must be a multiple of 8");
    end
    if (NUM_INPUTS < 1 || NUM_INPUTS > 16) begin : g_bad_inputs
        $error("axistream_rr_arbiter: NUM_INPUTS must be in 1..16");
    end

    arb_state_e      state_reg;
    logic [IDXW-1:0] rr_ptr_reg;
    logic [IDXW-1:0] grant_idx_reg;
    logic [PW-1:0]   src_payload [NUM_INPUTS];
    logic            slice_in_valid;
    logic            slice_in_ready;
    logic [PW-1:0]   slice_in_data;
    logic [PW-1:0]   slice_out_data;
    logic            beat_accept;

    // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_INPUTS-1:0] req,
                                                input logic [IDXW-1:0]       ptr);
        logic [2*NUM_INPUTS-1:0] dbl;
        logic [NUM_INPUTS-1:0]   rot;
        logic [IDXW-1:0]         off;
        logic [IDXW:0]           sum;
        dbl = {req, req};
        rot = NUM_INPUTS'(dbl >> ptr);
        off = '0;
        for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDXW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= NUM_EXT) begin
            sum = sum - NUM_EXT;
        end
        return sum[IDXW-1:0];
    endfunction

    function automatic logic [IDXW-1:0] next_idx(input logic [IDXW-1:0] idx);
        return (idx == LAST_IDX) ? '0 : idx + 1'b1;
    endfunction

    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_src
        assign src_payload[gi] = {s_tdata[gi*TDATA_WIDTH +: TDATA_WIDTH],
                                  s_tstrb[gi*KW +: KW],
                                  s_tkeep[gi*KW +: KW],
                                  s_tlast[gi],
                                  s_tid[gi*TID_WIDTH +: TID_WIDTH],
                                  s_tdest[gi*TDEST_WIDTH +: TDEST_WIDTH]};
        assign s_tready[gi] = (state_reg == BUSY) && (grant_idx_reg == IDXW'(gi)) && slice_in_ready;
    end

    assign slice_in_valid = (state_reg == BUSY) && s_tvalid[grant_idx_reg];
    assign slice_in_data  = src_payload[grant_idx_reg];
    assign beat_accept    = slice_in_valid && slice_in_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            grant_idx_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|s_tvalid) begin
                        grant_idx_reg <= rr_pick(s_tvalid, rr_ptr_reg);
                        state_reg     <= BUSY;
                    end
                end
                BUSY: begin
                    // Only the granted source's tlast can end the grant; stalls just wait.
                    if (beat_accept && s_tlast[grant_idx_reg]) begin
                        state_reg  <= IDLE;
                        rr_ptr_reg <= next_idx(grant_idx_reg);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    axistream_reg_slice #(
        .WIDTH(PW)
    ) u_slice (
        .aclk     (aclk),
        .areset   (areset),
        .in_valid (slice_in_valid),
        .in_ready (slice_in_ready),
        .in_data  (slice_in_data),
        .out_valid(m_tvalid),
        .out_ready(m_tready),
        .out_data (slice_out_data)
    );

    assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest} = slice_out_data;
    assign grant_idx = grant_idx_reg;
    assign busy      = (state_reg == BUSY);

endmodule

// File: tb/tb_axistream_rr_arbiter.sv
// Scoreboard bench for axistream_rr_arbiter: queued source packets, a queue-based
// round-robin reference model, and decoupled input/output monitors.
module tb_axistream_rr_arbiter;

    localparam int NI = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int IW = 4;
    localparam int TW = 4;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
        logic [KW-1:0] keep;
        logic          last;
        logic [IW-1:0] id;
        logic [TW-1:0] dest;
        int            gap;
    } beat_t;

    logic              aclk = 1'b0;
    logic              areset;
    logic [NI-1:0]     s_tvalid;
    logic [NI-1:0]     s_tready;
    logic [NI*DW-1:0]  s_tdata;
    logic [NI*KW-1:0]  s_tstrb;
    logic [NI*KW-1:0]  s_tkeep;
    logic [NI-1:0]     s_tlast;
    logic [NI*IW-1:0]  s_tid;
    logic [NI*TW-1:0]  s_tdest;
    logic              m_tvalid;
    logic              m_tready;
    logic [DW-1:0]     m_tdata;
    logic [KW-1:0]     m_tstrb;
    logic [KW-1:0]     m_tkeep;
    logic              m_tlast;
    logic [IW-1:0]     m_tid;
    logic [TW-1:0]     m_tdest;
    logic [1:0]        grant_idx;
    logic              busy;

    axistream_rr_arbiter #(
        .NUM_INPUTS(NI), .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(TW)
    ) dut (
        .aclk(aclk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tstrb(s_tstrb), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tid(s_tid), .s_tdest(s_tdest),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tid(m_tid), .m_tdest(m_tdest),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 aclk = ~aclk;

    int    checks = 0;
    int    failures = 0;
    int    cycle = 0;
    beat_t src_q [NI][$];
    beat_t stage_q [NI][$];
    beat_t exp_q [$];
    int    exp_src_q [$];
    int    out_cyc_q [$];
    int    gap_cnt [NI];
    int    model_ptr = 0;
    int    ready_mode = 0;
    bit    in_pkt = 0;
    int    cur_src = 0;
    int    in_hs_count = 0;
    int    tlast_in_cyc = -1;
    int    busy_fall_cyc = -1;

    function automatic logic [63:0] pack(input beat_t b);
        return 64'({b.data, b.strb, b.keep, b.last, b.id, b.dest});
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_pkt(input int src, input int len, input logic [DW-1:0] dbase,
                           input int stall_beat, input int stall_len);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = (dbase != 0) ? DW'(dbase * DW'(k + 1)) : DW'($urandom);
            b.strb = KW'($urandom);
            b.keep = KW'($urandom);
            b.last = (k == len - 1);
            b.id   = IW'($urandom);
            b.dest = TW'($urandom);
            b.gap  = (k != 0 && k == stall_beat) ? stall_len : 0;
            stage_q[src].push_back(b);
        end
    endtask

    // Reference model: among sources with pending packets, serve the first at or
    // after the pointer (cyclically), emit its whole packet, move pointer past it.
    task automatic commit();
        int    left [NI];
        int    s;
        bit    found;
        bit    any;
        beat_t b;
        for (int i = 0; i < NI; i++) begin
            left[i] = 0;
            foreach (stage_q[i][k]) begin
                src_q[i].push_back(stage_q[i][k]);
                if (stage_q[i][k].last) left[i]++;
            end
        end
        any = 1'b1;
        while (any) begin
            found = 1'b0;
            s = 0;
            for (int k = 0; k < NI; k++) begin
                if (!found && left[(model_ptr + k) % NI] > 0) begin
                    s = (model_ptr + k) % NI;
                    found = 1'b1;
                end
            end
            if (!found) begin
                any = 1'b0;
            end else begin
                exp_src_q.push_back(s);
                do begin
                    b = stage_q[s].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
                left[s]--;
                model_ptr = (s + 1) % NI;
            end
        end
    endtask

    task automatic flush_all();
        for (int i = 0; i < NI; i++) begin
            src_q[i].delete();
            stage_q[i].delete();
        end
        exp_q.delete();
        exp_src_q.delete();
        in_pkt = 0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        int pend;
        bit done = 0;
        while (!done) begin
            @(negedge aclk);
            n++;
            pend = 0;
            for (int i = 0; i < NI; i++) pend += src_q[i].size();
            if (pend == 0 && exp_q.size() == 0 && exp_src_q.size() == 0 && !busy && !m_tvalid) begin
                done = 1;
            end else if (n > budget) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout: got %0d beats outstanding, expected 0", exp_q.size());
                flush_all();
                done = 1;
            end
        end
        repeat (2) @(negedge aclk);
    endtask

    initial forever begin
        @(posedge aclk);
        cycle++;
    end

    // Source driver: tvalid only drops after a handshake, first beats never stall.
    initial begin
        s_tvalid = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
        s_tlast = '0; s_tid = '0; s_tdest = '0;
        for (int i = 0; i < NI; i++) gap_cnt[i] = 0;
        forever begin
            @(negedge aclk);
            if (!areset) begin
                for (int i = 0; i < NI; i++) begin
                    if (s_tvalid[i] && s_tready[i] && src_q[i].size() > 0) begin
                        void'(src_q[i].pop_front());
                        if (src_q[i].size() > 0) gap_cnt[i] = src_q[i][0].gap;
                    end
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < NI; i++) begin
                if (areset) begin
                    src_q[i].delete();
                    gap_cnt[i] = 0;
                    s_tvalid[i] = 1'b0;
                end else if (gap_cnt[i] > 0) begin
                    gap_cnt[i]--;
                    s_tvalid[i] = 1'b0;
                end else if (src_q[i].size() > 0) begin
                    s_tvalid[i] = 1'b1;
                    s_tdata[i*DW +: DW] = src_q[i][0].data;
                    s_tstrb[i*KW +: KW] = src_q[i][0].strb;
                    s_tkeep[i*KW +: KW] = src_q[i][0].keep;
                    s_tlast[i]          = src_q[i][0].last;
                    s_tid[i*IW +: IW]   = src_q[i][0].id;
                    s_tdest[i*TW +: TW] = src_q[i][0].dest;
                end else begin
                    s_tvalid[i] = 1'b0;
                end
            end
        end
    end

    initial begin
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int pidx = 0;
        m_tready = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            case (ready_mode)
                0: m_tready = 1'b1;
                1: m_tready = ($urandom_range(0, 99) < 65);
                default: begin
                    m_tready = pat[pidx];
                    pidx = (pidx + 1) % 4;
                end
            endcase
        end
    end

    // Input monitor: grant order and packet contiguity at the source side.
    initial forever begin
        @(negedge aclk);
        if (!areset && (s_tvalid & s_tready) != '0) begin
            check("hs_onehot", 64'($countones(s_tvalid & s_tready)), 64'd1);
            for (int i = 0; i < NI; i++) begin
                if (s_tvalid[i] && s_tready[i]) begin
                    if (!in_pkt) begin
                        if (exp_src_q.size() == 0) begin
                            check("grant_unexpected", 64'(i), 64'hFF);
                        end else begin
                            cur_src = exp_src_q.pop_front();
                            check("grant_src", 64'(i), 64'(cur_src));
                            check("grant_idx", 64'(grant_idx), 64'(cur_src));
                        end
                        in_pkt = 1;
                    end else begin
                        check("no_interleave", 64'(i), 64'(cur_src));
                    end
                    if (s_tlast[i]) begin
                        in_pkt = 0;
                        tlast_in_cyc = cycle;
                    end
                    in_hs_count++;
                end
            end
        end
    end

    // Output monitor: scoreboard pop per accepted beat, plus hold-while-stalled.
    initial begin
        bit          stall_prev = 0;
        bit          busy_prev = 0;
        logic [63:0] held = '0;
        logic [63:0] cur;
        beat_t       e;
        forever begin
            @(negedge aclk);
            cur = 64'({m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest});
            if (areset) begin
                stall_prev = 0;
                busy_prev = 0;
            end else begin
                if (stall_prev) check("stall_hold", cur, held);
                if (m_tvalid && m_tready) begin
                    out_cyc_q.push_back(cycle);
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", cur, 64'hDEAD);
                    end else begin
                        e = exp_q.pop_front();
                        check("out_beat", cur, pack(e));
                        $display("beat cyc=%0d data=%h tid=%h last=%b", cycle, m_tdata, m_tid, m_tlast);
                    end
                end
                stall_prev = m_tvalid && !m_tready;
                held = cur;
                if (busy_prev && !busy) busy_fall_cyc = cycle;
                busy_prev = busy;
            end
        end
    end

    initial begin
        int c;
        int base;
        int n;
        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_grant", 64'(grant_idx), 64'd0);
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);

        // Single source, 3 beats: latency and busy timing.
        ready_mode = 0;
        @(negedge aclk);
        out_cyc_q.delete();
        c = cycle;
        add_pkt(0, 3, 32'h11, -1, 0);
        commit();
        wait_drain(50);
        check("t1_nbeats", 64'(out_cyc_q.size()), 64'd3);
        for (int k = 0; k < 3 && k < out_cyc_q.size(); k++)
            check($sformatf("t1_out_cycle%0d", k), 64'(out_cyc_q[k] - c), 64'(3 + k));
        check("t1_busy_fall", 64'(busy_fall_cyc), 64'(tlast_in_cyc + 1));

        // Fairness: every source queues several single-beat packets.
        for (int r = 0; r < 3; r++)
            for (int s = 0; s < NI; s++) add_pkt(s, 1, 0, -1, 0);
        @(negedge aclk);
        commit();
        wait_drain(200);

        // No interleave: 1 and 3 start requesting while 2 is mid-packet.
        @(negedge aclk);
        add_pkt(2, 4, 0, -1, 0);
        commit();
        repeat (2) @(negedge aclk);
        add_pkt(1, 2, 0, -1, 0);
        add_pkt(3, 2, 0, -1, 0);
        commit();
        wait_drain(200);

        // Backpressure with m_tready pattern 1,0,0,1.
        ready_mode = 2;
        add_pkt(0, 6, 0, -1, 0);
        add_pkt(1, 3, 0, -1, 0);
        @(negedge aclk);
        commit();
        wait_drain(300);

        // Granted source stalls 5 cycles while source 3 waits.
        ready_mode = 0;
        @(negedge aclk);
        add_pkt(0, 4, 0, 2, 5);
        commit();
        @(negedge aclk);
        add_pkt(3, 2, 0, -1, 0);
        commit();
        wait_drain(200);

        // Randomised traffic, random gaps and random backpressure.
        ready_mode = 1;
        for (int r = 0; r < 5; r++) begin
            for (int s = 0; s < NI; s++) begin
                n = $urandom_range(0, 2);
                for (int p = 0; p < n; p++)
                    add_pkt(s, $urandom_range(1, 5), 0, $urandom_range(1, 4), $urandom_range(0, 3));
            end
            @(negedge aclk);
            commit();
            wait_drain(2000);
        end

        // Reset during beat 2 of a 4-beat packet.
        ready_mode = 0;
        @(negedge aclk);
        base = in_hs_count;
        add_pkt(1, 4, 0, -1, 0);
        commit();
        n = 0;
        while (in_hs_count < base + 1 && n < 50) begin
            @(negedge aclk);
            #1;
            n++;
        end
        check("mid_rst_first_beat", 64'(in_hs_count - base), 64'd1);
        @(posedge aclk);
        #2;
        areset = 1'b1;
        flush_all();
        model_ptr = 0;
        @(posedge aclk);
        #2 areset = 1'b0;
        @(negedge aclk);
        check("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_grant", 64'(grant_idx), 64'd0);
        check("mid_rst_s_tready", 64'(s_tready), 64'd0);

        // After reset the pointer restarts at source 0.
        for (int s = NI - 1; s >= 0; s--) add_pkt(s, 2, 0, -1, 0);
        @(negedge aclk);
        commit();
        wait_drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        failures++;
        $display("FAIL global_timeout: got no finish, expected finish before 1000000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
